// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - FIFO read-side stage presenting a framed valid/ready stream
//
// Drains the FIFO read port into a 2-entry buffer that absorbs the FIFO's
// one-cycle read latency. The buffer is presented as a valid/ready stream.
// Every PKT_LEN-th accepted beat is flagged as last, and completed packets
// are counted.
//
// Ports:
//   i_clk         clock, all state changes on the rising edge
//   i_reset       asynchronous active-low reset
//   i_fifo_empty  FIFO empty flag
//   o_r_ready     FIFO pop request (combinational, depends on i_m_ready)
//   i_data_out    FIFO read data, valid the cycle after the popping edge
//   o_m_valid     stream word valid
//   i_m_ready     downstream accept
//   o_m_data      stream word (buffer head)
//   o_m_last      final beat of a packet
//   o_pkt_cnt     completed packet count, wraps modulo 2^16

module fifo_stream_reader #(
  parameter int WIDTH   = 32,
  parameter int PKT_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_fifo_empty,
  output logic             o_r_ready,
  input  logic [WIDTH-1:0] i_data_out,
  output logic             o_m_valid,
  input  logic             i_m_ready,
  output logic [WIDTH-1:0] o_m_data,
  output logic             o_m_last,
  output logic [15:0]      o_pkt_cnt
);

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  logic [WIDTH-1:0] r_mem [0:1];
  logic             r_head;
  logic             r_tail;
  logic [1:0]       r_count;
  logic             r_rd_pend;
  logic [15:0]      r_beat;
  logic [15:0]      r_pkt_cnt;

  logic [1:0]       w_occ;
  logic             w_pop_out;
  logic             w_last_beat;

  // A word in flight from the FIFO already owns a buffer slot, so it is
  // counted as occupancy. r_rd_pend can only be set while occ < 2, or while
  // occ == 2 with a beat leaving, so occ never exceeds 2.
  assign w_occ       = r_count + {1'b0, r_rd_pend};
  assign w_pop_out   = o_m_valid & i_m_ready;
  assign w_last_beat = (r_beat == LAST_BEAT);

  // Popping when full is allowed only when a beat is leaving in the same
  // cycle. This creates a combinational path from i_m_ready to o_r_ready.
  // The path is what gives one word per cycle with a 2-entry buffer.
  assign o_r_ready = !i_fifo_empty &
                     ((w_occ < 2'd2) | ((w_occ == 2'd2) & w_pop_out));

  assign o_m_valid = (r_count != 2'd0);
  assign o_m_data  = r_mem[r_head];
  assign o_m_last  = o_m_valid & w_last_beat;
  assign o_pkt_cnt = r_pkt_cnt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < 2; i++) begin
        r_mem[i] <= '0;
      end
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_count   <= 2'd0;
      r_rd_pend <= 1'b0;
      r_beat    <= 16'd0;
      r_pkt_cnt <= 16'd0;
    end else begin
      // o_r_ready already includes !i_fifo_empty, so it is exactly "a pop occurs".
      r_rd_pend <= o_r_ready;

      if (r_rd_pend) begin
        r_mem[r_tail] <= i_data_out;
        r_tail        <= ~r_tail;
      end

      if (w_pop_out) begin
        r_head <= ~r_head;
        if (w_last_beat) begin
          r_beat    <= 16'd0;
          r_pkt_cnt <= r_pkt_cnt + 16'd1;
        end else begin
          r_beat <= r_beat + 16'd1;
        end
      end

      r_count <= r_count + {1'b0, r_rd_pend} - {1'b0, w_pop_out};
    end
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Downstream read-side stage for the `fifo` block: drains words from the FIFO read port and presents them as a valid/ready stream with packet framing. It owns the FIFO `r_ready` handshake, absorbs the FIFO's one-cycle read latency with a 2-entry output buffer, and sustains one word per cycle under full downstream readiness. It marks every `PKT_LEN`-th beat with `m_last` and counts completed packets for the FIR/SoC datapath that consumes the stream.

## Interface
- `WIDTH`, 32, data word width; must match the FIFO `WIDTH`.
- `PKT_LEN`, 4, beats per packet; legal range 1..65535.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `r_ready`  out  1  FIFO pop request; combinational.
- `data_out`  in  WIDTH  FIFO read data. Valid in the cycle after the edge that popped it.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  downstream accept.
- `m_data`  out  WIDTH  stream word.
- `m_last`  out  1  final beat of a packet.
- `pkt_cnt`  out  16  number of completed packets; wraps modulo 2^16.

## Operation
- FIFO read contract:
  - A pop occurs at a rising edge where `r_ready=1` and `fifo_empty=0`.
  - `data_out` holds the popped word during the following cycle.
- `rd_pend` (1 bit):
  - Set at every edge where a pop occurs; cleared otherwise.
  - At each edge where `rd_pend=1`, `data_out` is written into the buffer tail.
- Buffer:
  - 2-entry circular buffer with head pointer, tail pointer and count (0..2).
  - `occ = count + rd_pend` (0..2).
  - `pop_out = m_valid & m_ready`.
- `r_ready = !fifo_empty & (occ < 2 | (occ == 2 & pop_out))`.
  - This is a combinational path from `m_ready` to `r_ready`.
  - The buffer never overflows; words are never dropped or duplicated.
- Stream outputs:
  - `m_valid = (count != 0)`; `m_data` = head entry.
  - A simultaneous push and pop at one edge leaves count unchanged; both pointers advance.
- Framing:
  - `beat` counter (16 bits) increments on each `pop_out`.
  - When `beat == PKT_LEN-1`, `beat` wraps to 0 and `pkt_cnt` increments.
  - `m_last = m_valid & (beat == PKT_LEN-1)`.
  - With `PKT_LEN=1`, every beat is last.
- `m_valid`, once high, stays high and `m_data` stays stable until accepted.

## Timing
- Reset (asynchronous assert, any time) clears count, pointers, `rd_pend`, `beat` and `pkt_cnt`.
  - Outputs during reset: `m_valid=0`, `m_last=0`, `pkt_cnt=0`, `m_data=0`.
  - Buffer RAM is cleared, so `m_data=0`.
  - `r_ready` during reset follows its equation with `occ=0`, i.e. `!fifo_empty`.
- Reset mid-operation:
  - Buffered and in-flight words are discarded.
  - A partial packet is abandoned; after release, framing restarts at beat 0.
- Latency: a pop at edge E makes the word visible on `m_data` with `m_valid=1` after edge E+1.
- Throughput: with `m_ready` held high and the FIFO non-empty, there is one pop and one beat every cycle.
- Backpressure with `m_ready=0`:
  - At most 2 pops occur beyond the last accepted word.
  - `r_ready` then stays 0 until a beat is accepted.
- Empty FIFO: `r_ready` stays 0; `m_valid` falls after the buffer drains.

## Test plan
- Idle after reset, FIFO empty, 10 cycles:
  - `r_ready=0`, `m_valid=0`, `pkt_cnt=0` throughout.
- Write 0..9 into the FIFO, `m_ready=1`, `PKT_LEN=4`:
  - `m_data` sequence is 0..9 in order, with no gaps once streaming.
  - `m_last` is high on words 3 and 7 only.
  - `pkt_cnt=2` at the end; `beat=2` is left pending.
- FIFO holds 3 words (DEPTH=3), `m_ready=0` for 10 cycles:
  - Exactly 2 pops occur; the FIFO retains 1 word.
  - `m_data=0` is stable with `m_valid=1`.
  - Release `m_ready`: words 0, 1, 2 arrive in order.
- `m_ready` toggling 1,0,1,0 while the FIFO is fed 8 words:
  - All 8 words arrive in order, each exactly once.
  - `m_data` never changes while `m_valid=1` and `m_ready=0`.
- Assert `reset` low mid-packet after beat 1 of packet 0, with a word in flight:
  - Outputs go to reset values immediately (asynchronously).
  - After release, writing 0x10..0x13 yields `m_last` on 0x13 and `pkt_cnt=1`.
- `PKT_LEN=1`, 3 words 0xA, 0xB, 0xC:
  - `m_last=1` on every beat; `pkt_cnt=3`.
